vector_control_sequencer: RTL and testbench

Registered, handshaked successor to the processor's combinational control decoder. It accepts one decoded instruction header (type, func, imm, vector) per handshake and produces the full datapath control bundle. Vector instructions are issued as `BEATS = VLEN/LANES` consecutive micro-op beats, each tagged with a beat index. It sits between the fetch/decode stage and the execute stage and adds back-pressure, flush and illegal-instruction flagging.

---
 rtl/control_pkg.sv | 41 ++++
 rtl/control_decoder.sv | 74 +++++++
 rtl/vector_control_sequencer.sv | 104 ++++++++++
 tb/tb_vector_control_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types for the vector control sequencer: control bundle layout,
// instruction classes, function codes and sequencer states.
package control_pkg;

  typedef enum logic [1:0] {
    CTRL = 2'b00,
    MEM  = 2'b01,
    DATA = 2'b10,
    RSVD = 2'b11
  } inst_type_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

  localparam logic [1:0] F_JUMP_C  = 2'b00;  // conditional / unconditional jump
  localparam logic [1:0] F_JUMP_CD = 2'b01;
  localparam logic [1:0] F_STORE   = 2'b00;
  localparam logic [1:0] F_LOAD    = 2'b01;
  localparam logic [1:0] F_VEC_MAX = 2'b10;  // highest legal vector data func
  localparam logic [1:0] F_SCL_MAX = 2'b01;  // highest legal scalar data func

  typedef struct packed {
    logic       illegal;
    logic       jump_i;
    logic       jump_ci;
    logic       jump_cd;
    logic       mem_to_reg;
    logic       mem_write;
    logic       imm_src;
    logic       vector_op;
    logic       alu_src1;
    logic       alu_src3;
    logic       reg_v_write;
    logic       reg_s_write;
    logic [1:0] alu_op;
    logic [1:0] alu_src2;
  } ctrl_bundle_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational header decode into the datapath control bundle; undefined
// encodings yield an all-zero bundle with only the illegal flag set.
module control_decoder
  import control_pkg::*;
(
  input  logic [1:0]   instruction_type,
  input  logic [1:0]   func,
  input  logic         imm,
  input  logic         vector,
  output ctrl_bundle_t bundle
);

  always_comb begin
    bundle = '0;
    case (inst_type_e'(instruction_type))
      CTRL: begin
        if (func == F_JUMP_C && !imm) begin
          bundle.jump_ci  = 1'b1;
          bundle.imm_src  = 1'b1;
          bundle.alu_src2 = 2'b11;
        end else if (func == F_JUMP_C && imm) begin
          bundle.jump_i   = 1'b1;
          bundle.alu_src2 = 2'b10;
        end else if (func == F_JUMP_CD && !imm) begin
          bundle.jump_cd  = 1'b1;
          bundle.imm_src  = 1'b1;
          bundle.alu_src2 = 2'b11;
        end else begin
          bundle.illegal  = 1'b1;
        end
      end
      MEM: begin
        if (func == F_STORE || func == F_LOAD) begin
          bundle.imm_src   = 1'b1;
          bundle.alu_src2  = 2'b10;
          bundle.alu_src1  = vector;
          bundle.vector_op = vector;
          if (func == F_STORE) begin
            bundle.mem_write = 1'b1;
          end else begin
            bundle.mem_to_reg  = 1'b1;
            bundle.reg_v_write = vector;
            bundle.reg_s_write = !vector;
          end
        end else begin
          bundle.illegal = 1'b1;
        end
      end
      DATA: begin
        if (imm) begin
          bundle.alu_src2    = 2'b10;
          bundle.imm_src     = 1'b1;
          bundle.reg_s_write = 1'b1;
          bundle.alu_op      = func;
        end else if (!vector && func <= F_SCL_MAX) begin
          bundle.alu_src2    = 2'b01;
          bundle.alu_op      = func;
          bundle.reg_s_write = 1'b1;
        end else if (vector && func <= F_VEC_MAX) begin
          bundle.alu_src2    = 2'b01;
          bundle.alu_op      = func;
          bundle.alu_src1    = 1'b1;
          bundle.alu_src3    = 1'b1;
          bundle.vector_op   = 1'b1;
          bundle.reg_v_write = 1'b1;
        end else begin
          bundle.illegal = 1'b1;
        end
      end
      default: bundle.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/vector_control_sequencer.sv
// Registered control sequencer: accepts one instruction header per handshake
// and issues its decoded bundle as one beat, or BEATS beats for vector ops.
module vector_control_sequencer
  import control_pkg::*;
#(
  parameter  int VLEN  = 8,
  parameter  int LANES = 4,
  localparam int BEATS = VLEN / LANES,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    instruction_type,
  input  logic [1:0]    func,
  input  logic          imm,
  input  logic          vector,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          JumpI,
  output logic          JumpCI,
  output logic          JumpCD,
  output logic          MemToReg,
  output logic          MemWrite,
  output logic          ImmSrc,
  output logic          VectorOp,
  output logic          ALUSrc1,
  output logic          ALUSrc3,
  output logic          RegVWrite,
  output logic          RegSWrite,
  output logic [1:0]    ALUOp,
  output logic [1:0]    ALUSrc2,
  output logic [BW-1:0] beat,
  output logic          last,
  output logic          illegal
);

  if (VLEN % LANES != 0 || LANES < 1 || LANES > VLEN) begin : g_bad_geometry
    $error("vector_control_sequencer: VLEN must be a positive multiple of LANES");
  end

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  seq_state_e   state_reg;
  logic [BW-1:0] beat_reg;
  ctrl_bundle_t bundle_reg;
  ctrl_bundle_t bundle_next;
  logic         accept;
  logic         advance;

  control_decoder u_decoder (
    .instruction_type (instruction_type),
    .func             (func),
    .imm              (imm),
    .vector           (vector),
    .bundle           (bundle_next)
  );

  assign out_valid = (state_reg == ISSUE);
  assign last      = out_valid && (!bundle_reg.vector_op || beat_reg == LAST_BEAT);
  assign advance   = out_valid && out_ready;
  // A new header is taken when idle or as the final beat retires, never during flush/reset.
  assign in_ready  = rst && !flush && ((state_reg == IDLE) || (advance && last));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      bundle_reg <= '0;
    end else if (accept) begin
      state_reg  <= ISSUE;
      beat_reg   <= '0;
      bundle_reg <= bundle_next;
    end else if (advance) begin
      if (last) begin
        state_reg  <= IDLE;
        beat_reg   <= '0;
        bundle_reg <= '0;
      end else begin
        beat_reg <= beat_reg + 1'b1;
      end
    end
  end

  assign beat      = beat_reg;
  assign illegal   = bundle_reg.illegal;
  assign JumpI     = bundle_reg.jump_i;
  assign JumpCI    = bundle_reg.jump_ci;
  assign JumpCD    = bundle_reg.jump_cd;
  assign MemToReg  = bundle_reg.mem_to_reg;
  assign MemWrite  = bundle_reg.mem_write;
  assign ImmSrc    = bundle_reg.imm_src;
  assign VectorOp  = bundle_reg.vector_op;
  assign ALUSrc1   = bundle_reg.alu_src1;
  assign ALUSrc3   = bundle_reg.alu_src3;
  assign RegVWrite = bundle_reg.reg_v_write;
  assign RegSWrite = bundle_reg.reg_s_write;
  assign ALUOp     = bundle_reg.alu_op;
  assign ALUSrc2   = bundle_reg.alu_src2;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Bench for vector_control_sequencer: queue-based beat model checked every
// cycle, plus directed vectors with literal expectations.
module tb_vector_control_sequencer;

  localparam int VLEN  = 8;
  localparam int LANES = 4;
  localparam int BEATS = VLEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, imm, vector, out_valid, out_ready;
  logic [1:0]    instruction_type, func;
  logic          JumpI, JumpCI, JumpCD, MemToReg, MemWrite, ImmSrc, VectorOp;
  logic          ALUSrc1, ALUSrc3, RegVWrite, RegSWrite, last, illegal;
  logic [1:0]    ALUOp, ALUSrc2;
  logic [BW-1:0] beat;

  int checks   = 0;
  int failures = 0;

  vector_control_sequencer #(.VLEN(VLEN), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_type(instruction_type), .func(func), .imm(imm), .vector(vector),
    .out_valid(out_valid), .out_ready(out_ready),
    .JumpI(JumpI), .JumpCI(JumpCI), .JumpCD(JumpCD), .MemToReg(MemToReg),
    .MemWrite(MemWrite), .ImmSrc(ImmSrc), .VectorOp(VectorOp), .ALUSrc1(ALUSrc1),
    .ALUSrc3(ALUSrc3), .RegVWrite(RegVWrite), .RegSWrite(RegSWrite),
    .ALUOp(ALUOp), .ALUSrc2(ALUSrc2), .beat(beat), .last(last), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Bundle order: illegal, JumpI, JumpCI, JumpCD, MemToReg, MemWrite, ImmSrc,
  // VectorOp, ALUSrc1, ALUSrc3, RegVWrite, RegSWrite, ALUOp[1:0], ALUSrc2[1:0]
  wire [15:0] act_bundle = {illegal, JumpI, JumpCI, JumpCD, MemToReg, MemWrite, ImmSrc,
                            VectorOp, ALUSrc1, ALUSrc3, RegVWrite, RegSWrite, ALUOp, ALUSrc2};

  function automatic logic [15:0] mk(logic ill, logic ji, logic jci, logic jcd, logic m2r,
                                     logic mw, logic is, logic vop, logic a1, logic a3,
                                     logic rv, logic rs, logic [1:0] op, logic [1:0] s2);
    return {ill, ji, jci, jcd, m2r, mw, is, vop, a1, a3, rv, rs, op, s2};
  endfunction

  function automatic logic [15:0] model_bundle(logic [1:0] t, logic [1:0] f, logic i, logic v);
    if (t == 2'd0 && f == 2'd0 && !i) return mk(0,0,1,0,0,0,1,0,0,0,0,0,2'd0,2'b11);
    if (t == 2'd0 && f == 2'd0 && i)  return mk(0,1,0,0,0,0,0,0,0,0,0,0,2'd0,2'b10);
    if (t == 2'd0 && f == 2'd1 && !i) return mk(0,0,0,1,0,0,1,0,0,0,0,0,2'd0,2'b11);
    if (t == 2'd1 && f == 2'd0)       return mk(0,0,0,0,0,1,1,v,v,0,0,0,2'd0,2'b10);
    if (t == 2'd1 && f == 2'd1)       return mk(0,0,0,0,1,0,1,v,v,0,v,!v,2'd0,2'b10);
    if (t == 2'd2 && i)               return mk(0,0,0,0,0,0,1,0,0,0,0,1,f,2'b10);
    if (t == 2'd2 && !v && f <= 2'd1) return mk(0,0,0,0,0,0,0,0,0,0,0,1,f,2'b01);
    if (t == 2'd2 && v && f <= 2'd2)  return mk(0,0,0,0,0,0,0,1,1,1,1,0,f,2'b01);
    return 16'h8000;
  endfunction

  typedef struct {
    logic [15:0] bundle;
    int          beat_idx;
    logic        is_last;
  } beat_t;

  beat_t pending[$];

  function automatic logic model_in_ready();
    return rst && !flush && (pending.size() == 0 || (pending.size() == 1 && out_ready));
  endfunction

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update from the values presented at each rising edge.
  always @(posedge clk) begin
    logic        acc;
    logic [15:0] b;
    int          n;
    acc = in_valid && model_in_ready();
    if (!rst || flush) begin
      pending.delete();
    end else begin
      if (pending.size() > 0 && out_ready) void'(pending.pop_front());
      if (acc) begin
        b = model_bundle(instruction_type, func, imm, vector);
        n = b[8] ? BEATS : 1;
        for (int k = 0; k < n; k++) pending.push_back('{b, k, (k == n - 1)});
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(model_in_ready()));
    check("out_valid", 32'(out_valid), 32'(pending.size() > 0));
    if (pending.size() > 0) begin
      check("bundle", 32'(act_bundle), 32'(pending[0].bundle));
      check("beat", 32'(beat), 32'(pending[0].beat_idx));
      check("last", 32'(last), 32'(pending[0].is_last));
      $display("beat bundle=%04h beat=%0d last=%0d ready=%0d", act_bundle, beat, last, out_ready);
    end
  end

  task automatic send(logic [1:0] t, logic [1:0] f, logic i, logic v, logic orr);
    logic got;
    instruction_type = t; func = f; imm = i; vector = v;
    in_valid = 1'b1; out_ready = orr; flush = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(logic orr, int n);
    in_valid = 1'b0; flush = 1'b0; out_ready = orr;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; instruction_type = 2'b10; func = 2'b11; imm = 1'b1; vector = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_bundle", 32'(act_bundle), 32'd0);
    check("reset_beat_last", 32'({beat, last}), 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    idle(1'b1, 1);
    check("no_issue_before_hs", 32'(out_valid), 32'd0);

    // add imm
    send(2'b10, 2'b11, 1'b1, 1'b0, 1'b1);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_fields", 32'({ALUOp, ALUSrc2, ImmSrc, RegSWrite, VectorOp}), 32'b11_10_1_1_0);
    check("addi_beat_last", 32'({beat, last}), 32'({1'b0, 1'b1}));

    // vector load, then a scalar queued behind it
    send(2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
    check("vld_b0", 32'({beat, last}), 32'd0);
    check("vld_fields", 32'({RegVWrite, MemToReg, ALUSrc1, VectorOp}), 32'hF);
    send(2'b10, 2'b11, 1'b1, 1'b0, 1'b1);
    check("b2b_scalar", 32'({out_valid, RegSWrite, VectorOp}), 32'b110);
    idle(1'b1, 1);

    // vector data op with back-pressure
    send(2'b10, 2'b10, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 2);
    check("stall_b0", 32'({out_valid, beat}), 32'({1'b1, 1'b0}));
    idle(1'b1, 1);
    idle(1'b0, 1);
    check("stall_b1", 32'({out_valid, beat, last, ALUOp}), 32'({1'b1, 1'b1, 1'b1, 2'b10}));
    idle(1'b1, 1);
    check("stall_done", 32'(out_valid), 32'd0);

    // flush on beat 0, with a competing in_valid
    send(2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
    instruction_type = 2'b10; func = 2'b11; imm = 1'b1; vector = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    #1;
    check("post_flush_ready", 32'(in_ready), 32'd1);
    idle(1'b1, 2);

    // illegal encodings
    send(2'b11, 2'b01, 1'b1, 1'b1, 1'b1);
    check("illegal_t11", 32'({illegal, VectorOp, last}), 32'b101);
    send(2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
    check("illegal_ctl", 32'(act_bundle), 32'h8000);
    idle(1'b1, 1);

    // every header encoding, back to back
    for (int c = 0; c < 64; c++) begin
      logic [5:0] cv;
      cv = 6'(c);
      send(cv[5:4], cv[3:2], cv[1], cv[0], 1'b1);
    end
    idle(1'b1, 3);

    // reset mid-sequence
    send(2'b01, 2'b00, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'({out_valid, beat, last}), 32'd0);
    rst = 1'b1;
    idle(1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
